// File: rtl/cdm16_err_stats.sv
// Error statistics collector for a 16x16 carry-disregard multiplier: compares each
// returned product R against the exact A*B and accumulates sum, count and max of |error|.
module cdm16_err_stats #(
  parameter int CNT_W = 16,
  parameter int ACC_W = 48
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] target,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      A,
  input  logic [15:0]      B,
  input  logic [31:0]      R,
  output logic             busy,
  output logic             done,
  output logic [ACC_W-1:0] err_sum,
  output logic [CNT_W-1:0] err_cnt,
  output logic [31:0]      max_err
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

  state_e           state_q,    state_d;
  logic [CNT_W-1:0] target_q,   target_d;
  logic [CNT_W-1:0] acc_cnt_q,  acc_cnt_d;
  logic             s1_valid_q, s1_valid_d;
  logic [31:0]      s1_prod_q,  s1_prod_d;
  logic [31:0]      s1_r_q,     s1_r_d;
  logic             s2_valid_q, s2_valid_d;
  logic [31:0]      s2_diff_q,  s2_diff_d;
  logic [ACC_W-1:0] err_sum_q,  err_sum_d;
  logic [CNT_W-1:0] err_cnt_q,  err_cnt_d;
  logic [31:0]      max_err_q,  max_err_d;

  logic             accept;
  logic [ACC_W:0]   sum_wide;

  assign in_ready = (state_q == S_RUN) && (acc_cnt_q < target_q);
  assign accept   = in_valid && in_ready;

  always_comb begin
    // NOTE: every signal written here gets a default first so no path can infer a latch.
    state_d    = state_q;
    target_d   = target_q;
    acc_cnt_d  = acc_cnt_q;
    s1_valid_d = accept;
    s1_prod_d  = s1_prod_q;
    s1_r_d     = s1_r_q;
    s2_valid_d = s1_valid_q;
    s2_diff_d  = s2_diff_q;
    err_sum_d  = err_sum_q;
    err_cnt_d  = err_cnt_q;
    max_err_d  = max_err_q;
    sum_wide   = {1'b0, err_sum_q} + {{(ACC_W-31){1'b0}}, s2_diff_q};

    if (accept) begin
      s1_prod_d = {16'h0000, A} * {16'h0000, B};
      s1_r_d    = R;
      acc_cnt_d = acc_cnt_q + CNT_W'(1);
    end

    // Subtract in whichever order keeps the result non-negative; R may exceed the exact product.
    if (s1_valid_q) begin
      s2_diff_d = (s1_prod_q >= s1_r_q) ? (s1_prod_q - s1_r_q) : (s1_r_q - s1_prod_q);
    end

    if (s2_valid_q) begin
      err_sum_d = sum_wide[ACC_W] ? '1 : sum_wide[ACC_W-1:0];
      if ((s2_diff_q != '0) && (err_cnt_q != '1)) begin
        err_cnt_d = err_cnt_q + CNT_W'(1);
      end
      if (s2_diff_q > max_err_q) begin
        max_err_d = s2_diff_q;
      end
    end

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          target_d  = target;
          acc_cnt_d = '0;
          err_sum_d = '0;
          err_cnt_d = '0;
          max_err_d = '0;
          state_d   = (target == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (accept && (acc_cnt_d == target_q)) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!s1_valid_q && !s2_valid_q) begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    if (rst) begin
      state_q    <= S_IDLE;
      target_q   <= '0;
      acc_cnt_q  <= '0;
      s1_valid_q <= 1'b0;
      s1_prod_q  <= '0;
      s1_r_q     <= '0;
      s2_valid_q <= 1'b0;
      s2_diff_q  <= '0;
      err_sum_q  <= '0;
      err_cnt_q  <= '0;
      max_err_q  <= '0;
    end else begin
      state_q    <= state_d;
      target_q   <= target_d;
      acc_cnt_q  <= acc_cnt_d;
      s1_valid_q <= s1_valid_d;
      s1_prod_q  <= s1_prod_d;
      s1_r_q     <= s1_r_d;
      s2_valid_q <= s2_valid_d;
      s2_diff_q  <= s2_diff_d;
      err_sum_q  <= err_sum_d;
      err_cnt_q  <= err_cnt_d;
      max_err_q  <= max_err_d;
    end
  end

  assign busy    = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done    = (state_q == S_DONE);
  assign err_sum = err_sum_q;
  assign err_cnt = err_cnt_q;
  assign max_err = max_err_q;

endmodule
